uart_echo_buffer: RTL and testbench
===================================

# uart_echo_buffer

Buffered echo core between the RS232 `receiver` and `transmitter`, replacing the direct unbuffered loopback wiring. Received bytes are queued in a parametrised FIFO and launched to the transmitter only when it is idle, so back-to-back input is never lost while `TxD_busy` is high. An optional line mode holds bytes until a terminator arrives, then echoes the whole line. Overflow is reported by a sticky flag.

## Interface
- `DATA_W`, 8: character width in bits.
- `DEPTH`, 16: FIFO entries; power of two, at least 4.
- `TERM`, 8'h0D: line terminator used in line mode (CR).
- `CNT_W`, $clog2(DEPTH)+1: width of the occupancy count.

- `clk`  in  1  system clock (50 MHz on the board).
- `rst_n`  in  1  asynchronous active-low reset.
- `line_mode`  in  1  1 = line-buffered echo; 0 = byte echo.
- `rx_valid`  in  1  one-cycle pulse from receiver `RxD_data_ready`.
- `rx_data`  in  DATA_W  received character; valid with `rx_valid`.
- `tx_start`  out  1  one-cycle pulse to transmitter `TxD_start`.
- `tx_data`  out  DATA_W  character to transmitter `TxD_Data`; stable from `tx_start` until the next launch.
- `tx_busy`  in  1  transmitter `TxD_busy`.
- `fifo_count`  out  CNT_W  entries currently held (0..DEPTH).
- `overrun`  out  1  sticky; set when a byte is dropped on a full FIFO.
- `overrun_clr`  in  1  synchronous clear of `overrun`.

## Operation
- Write side: on `rx_valid` with FIFO not full (after accounting for a same-cycle pop), write `rx_data` at `wr_ptr` and increment it. If the FIFO is full and no pop occurs that cycle, drop the byte and set `overrun`.
- Commit pointer `cm_ptr` marks the end of the releasable region:
  - `line_mode`=0: `cm_ptr` follows `wr_ptr` every cycle.
  - `line_mode`=1: `cm_ptr` updates to the post-write `wr_ptr` only when the written byte equals `TERM`, or when the write makes the FIFO full. The full-FIFO forced commit prevents deadlock.
  - Switching 1→0 releases all held bytes on the next cycle. Switching 0→1 leaves the already-committed bytes releasable.
- Launch FSM:
  - IDLE: when `rd_ptr`≠`cm_ptr` and `tx_busy`=0, pop the head into the `tx_data` register and go to LAUNCH.
  - LAUNCH: assert `tx_start` for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when `tx_busy`=1. If `tx_busy` has not risen after 2 cycles in this state, return to IDLE (transmitter treated as done).
  - WAIT_DONE: go to IDLE when `tx_busy`=0.
- `overrun` has priority: a set and a clear in the same cycle leaves `overrun`=1.
- Pointers are CNT_W bits wide; full and empty are distinguished by the MSB. Wrap-around is natural modulo 2·DEPTH.

## Timing
- Reset (async assert, sync release) values: `tx_start`=0, `tx_data`=0, `fifo_count`=0, `overrun`=0. All pointers are 0 and the FSM is in IDLE.
- Byte-mode latency with the FIFO empty and the transmitter idle:
  - cycle 0: `rx_valid`.
  - cycle 1: data visible in the FIFO, `fifo_count`=1.
  - cycle 2: pop; `tx_data` loads at the end of this cycle.
  - cycle 3: `tx_start`=1.
- `fifo_count` is registered: it reflects pushes and pops one cycle after the event. A simultaneous push and pop leaves it unchanged.
- At most one launch per transmitter busy period; `tx_start` never asserts while in WAIT_BUSY or WAIT_DONE.
- Reset mid-transmission drops queued data. `tx_start` is not re-issued after reset.

## Structure
- Package `uart_echo_pkg`: the FSM state enum (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE), the default `TERM` constant, and the WAIT_BUSY timeout constant (2).
- Sub-module `uart_sync_fifo` holds the storage array plus the write and read pointers. Commit logic, `overrun`, and the FSM stay in the top.
- The board top instantiates `receiver` → `uart_echo_buffer` → `transmitter`.

## Test plan
- Byte mode, single byte 8'h41 with the transmitter model idle → `tx_start` 3 cycles after `rx_valid`, `tx_data`=8'h41, `fifo_count` returns to 0.
- Byte mode, 5 bytes 8'h30..8'h34 at 1-cycle spacing, with the transmitter model busy for 100 cycles per byte → exactly 5 `tx_start` pulses in order, no `overrun`, peak `fifo_count`=4 or 5.
- Line mode, "AB" then 8'h0D → no `tx_start` before the CR is written; afterwards 8'h41, 8'h42, 8'h0D are echoed in order.
- Line mode, DEPTH+1 bytes with no CR → forced commit at full; DEPTH bytes echoed; the last byte is dropped if it arrives while full, with `overrun`=1. `overrun_clr` then clears the flag.
- Transmitter model that never raises `tx_busy` → FSM returns to IDLE 2 cycles after WAIT_BUSY is entered, and the next byte launches normally.
- Assert `rst_n`=0 with 3 bytes queued in WAIT_DONE → all outputs at reset values immediately; no `tx_start` after release until new input arrives.

Source files
------------

// File: rtl/uart_echo_pkg.sv
// rtl/uart_echo_pkg.sv - shared types and constants for the buffered UART echo core
package uart_echo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } echo_state_e;

    localparam logic [7:0] TERM_DEFAULT = 8'h0D;

    // Cycles spent waiting for TxD_busy to rise before the launch is treated as complete
    localparam int unsigned WAIT_BUSY_TIMEOUT = 2;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - character storage with extended-width write/read pointers
module uart_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  wr_ptr,
    output logic [CNT_W-1:0]  rd_ptr,
    output logic [CNT_W-1:0]  wr_ptr_next,
    output logic [CNT_W-1:0]  rd_ptr_next
);

    localparam int AW = CNT_W - 1;
    localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  wr_ptr_d;
    logic [CNT_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  rd_ptr_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; only pointer-qualified entries are ever read
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    assign rd_data     = mem_q[rd_ptr_q[AW-1:0]];
    assign wr_ptr      = wr_ptr_q;
    assign rd_ptr      = rd_ptr_q;
    assign wr_ptr_next = wr_ptr_d;
    assign rd_ptr_next = rd_ptr_d;

endmodule

// File: rtl/uart_echo_buffer.sv
// rtl/uart_echo_buffer.sv - buffered receiver-to-transmitter echo with optional line mode
module uart_echo_buffer
    import uart_echo_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                DEPTH  = 16,
    parameter logic [DATA_W-1:0] TERM   = DATA_W'(TERM_DEFAULT),
    parameter int                CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              line_mode,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_busy,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int AW = CNT_W - 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [1:0]       WB_LAST   = 2'(WAIT_BUSY_TIMEOUT - 1);

    echo_state_e       state_q;
    echo_state_e       state_d;
    logic [1:0]        timer_q;
    logic [1:0]        timer_d;
    logic [DATA_W-1:0] tx_data_q;
    logic [DATA_W-1:0] tx_data_d;
    logic [CNT_W-1:0]  cm_ptr_q;
    logic [CNT_W-1:0]  cm_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              overrun_q;
    logic              overrun_d;

    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  wr_ptr_next;
    logic [CNT_W-1:0]  rd_ptr_next;
    logic [CNT_W-1:0]  occ_next;
    logic              full;
    logic              releasable;
    logic              pop;
    logic              push;
    logic              drop;

    uart_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_data   (rx_data),
        .pop         (pop),
        .rd_data     (rd_data),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .wr_ptr_next (wr_ptr_next),
        .rd_ptr_next (rd_ptr_next)
    );

    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign releasable = (rd_ptr != cm_ptr_q);
    assign pop        = (state_q == ST_IDLE) && releasable && !tx_busy;
    assign push       = rx_valid && (!full || pop);
    assign drop       = rx_valid && full && !pop;
    assign occ_next   = wr_ptr_next - rd_ptr_next;

    // Line mode commits on the terminator, or when the FIFO fills so a CR-less line cannot stall it
    always_comb begin
        cm_ptr_d = cm_ptr_q;
        if (!line_mode) begin
            cm_ptr_d = wr_ptr;
        end else if (push && ((rx_data == TERM) || (occ_next == DEPTH_CNT))) begin
            cm_ptr_d = wr_ptr_next;
        end
    end

    always_comb begin
        count_d   = occ_next;
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        tx_data_d = pop ? rd_data : tx_data_q;
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        tx_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (pop) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tx_start = 1'b1;
                timer_d  = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == WB_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 2'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            tx_data_q <= '0;
            cm_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            tx_data_q <= tx_data_d;
            cm_ptr_q  <= cm_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// tb/tb_uart_echo_buffer.sv - randomized self-checking bench with a queue-based echo model
module tb_uart_echo_buffer;

    localparam int         DATA_W = 8;
    localparam int         DEPTH  = 16;
    localparam int         CNT_W  = 5;
    localparam logic [7:0] TERM   = 8'h0D;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              line_mode = 1'b0;
    logic              rx_valid = 1'b0;
    logic [DATA_W-1:0] rx_data = '0;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy = 1'b0;
    logic [CNT_W-1:0]  fifo_count;
    logic              overrun;
    logic              overrun_clr = 1'b0;

    uart_echo_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TERM   (TERM),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line_mode   (line_mode),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .fifo_count  (fifo_count),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #10 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         acc_cnt = 0;
    int         rel_cnt = 0;
    int         echo_cnt = 0;
    int         start_cnt = 0;
    int         last_start_cyc = 0;
    int         prev_start_cyc = 0;
    int         peak = 0;
    bit         tx_hold = 1'b0;
    bit         tx_never = 1'b0;
    int         busy_len = 4;
    int         busy_left = 0;
    logic       prev_start = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Echo scoreboard plus transmitter model, both evaluated mid-cycle
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (tx_start) begin
                check_eq("start_pulse", 32'(prev_start), 32'(0));
                check_eq("start_not_busy", 32'(tx_busy), 32'(0));
                check_eq("start_has_data", 32'(exp_q.size() != 0), 32'(1));
                if (exp_q.size() != 0) begin
                    check_eq("echo_released", 32'(echo_cnt < rel_cnt), 32'(1));
                    check_eq("echo_data", 32'(tx_data), 32'(exp_q.pop_front()));
                    echo_cnt++;
                end
                start_cnt++;
                prev_start_cyc = last_start_cyc;
                last_start_cyc = cyc;
            end
        end
        prev_start = tx_start;
        if (!rst_n) begin
            tx_busy   = 1'b0;
            busy_left = 0;
        end else if (tx_hold) begin
            tx_busy = 1'b1;
        end else if (tx_start && !tx_never) begin
            tx_busy   = 1'b1;
            busy_left = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end else begin
            tx_busy = 1'b0;
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] d, input bit accepted, input bit force_commit);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = d;
        if (accepted) begin
            exp_q.push_back(d);
            acc_cnt++;
            if (!line_mode || d == TERM || force_commit) rel_cnt = acc_cnt;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid    = 1'b0;
            overrun_clr = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        idle(1);
        while ((exp_q.size() != 0 || tx_busy) && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check_eq("drain_done", 32'(exp_q.size()), 32'(0));
        idle(4);
        check_eq("count_empty", 32'(fifo_count), 32'(0));
        exp_q.delete();
        acc_cnt  = 0;
        rel_cnt  = 0;
        echo_cnt = 0;
    endtask

    function automatic logic [7:0] nonterm();
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        if (d == TERM) d = 8'h0E;
        return d;
    endfunction

    initial begin
        int t0;
        int s0;
        int len;
        logic [7:0] d;
        bit mode;

        idle(3);
        check_eq("rst_tx_start", 32'(tx_start), 32'(0));
        check_eq("rst_tx_data", 32'(tx_data), 32'(0));
        check_eq("rst_fifo_count", 32'(fifo_count), 32'(0));
        check_eq("rst_overrun", 32'(overrun), 32'(0));
        rst_n = 1'b1;
        idle(2);

        // single byte latency
        busy_len = 4;
        send_byte(8'h41, 1'b1, 1'b0);
        t0 = cyc;
        idle(1);
        check_eq("t1_count_one", 32'(fifo_count), 32'(1));
        idle(4);
        check_eq("t1_latency", 32'(last_start_cyc - t0), 32'(3));
        drain();

        // back-to-back bytes against a slow transmitter
        busy_len = 100;
        peak = 0;
        s0 = start_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b1, 1'b0);
        drain();
        check_eq("t2_starts", 32'(start_cnt - s0), 32'(5));
        check_eq("t2_overrun", 32'(overrun), 32'(0));
        check_eq("t2_peak_4_or_5", 32'(peak == 4 || peak == 5), 32'(1));

        // line mode holds until CR
        busy_len = 3;
        line_mode = 1'b1;
        s0 = start_cnt;
        send_byte(8'h41, 1'b1, 1'b0);
        send_byte(8'h42, 1'b1, 1'b0);
        idle(20);
        check_eq("t3_hold", 32'(start_cnt - s0), 32'(0));
        send_byte(TERM, 1'b1, 1'b0);
        drain();
        check_eq("t3_starts", 32'(start_cnt - s0), 32'(3));

        // leaving line mode releases held bytes
        s0 = start_cnt;
        send_byte(8'h58, 1'b1, 1'b0);
        send_byte(8'h59, 1'b1, 1'b0);
        idle(10);
        check_eq("t3b_hold", 32'(start_cnt - s0), 32'(0));
        line_mode = 1'b0;
        rel_cnt = acc_cnt;
        drain();
        check_eq("t3b_starts", 32'(start_cnt - s0), 32'(2));

        // fill without CR: forced commit, drop, sticky flag
        line_mode = 1'b1;
        tx_hold = 1'b1;
        idle(2);
        for (int i = 0; i < DEPTH; i++) send_byte(nonterm(), 1'b1, i == DEPTH - 1);
        send_byte(nonterm(), 1'b0, 1'b0);
        idle(1);
        check_eq("t4_count_full", 32'(fifo_count), 32'(DEPTH));
        check_eq("t4_overrun_set", 32'(overrun), 32'(1));
        overrun_clr = 1'b1;
        idle(1);
        check_eq("t4_overrun_clr", 32'(overrun), 32'(0));
        send_byte(nonterm(), 1'b0, 1'b0);
        overrun_clr = 1'b1;
        idle(1);
        check_eq("t4_set_beats_clr", 32'(overrun), 32'(1));
        overrun_clr = 1'b1;
        idle(1);
        check_eq("t4_overrun_clr2", 32'(overrun), 32'(0));
        check_eq("t4_count_still_full", 32'(fifo_count), 32'(DEPTH));
        s0 = start_cnt;
        tx_hold = 1'b0;
        drain();
        check_eq("t4_starts", 32'(start_cnt - s0), 32'(DEPTH));
        line_mode = 1'b0;

        // transmitter that never reports busy
        tx_never = 1'b1;
        s0 = start_cnt;
        send_byte(8'h61, 1'b1, 1'b0);
        t0 = cyc;
        send_byte(8'h62, 1'b1, 1'b0);
        idle(15);
        check_eq("t5_starts", 32'(start_cnt - s0), 32'(2));
        check_eq("t5_first_latency", 32'(prev_start_cyc - t0), 32'(3));
        check_eq("t5_timeout_gap", 32'(last_start_cyc - prev_start_cyc), 32'(4));
        tx_never = 1'b0;
        busy_len = 5;
        send_byte(8'h63, 1'b1, 1'b0);
        drain();

        // reset while waiting on the transmitter with bytes queued
        busy_len = 100;
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h51 + i), 1'b1, 1'b0);
        idle(10);
        check_eq("t6_one_launched", 32'(start_cnt - s0), 32'(1));
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_tx_start", 32'(tx_start), 32'(0));
        check_eq("t6_rst_tx_data", 32'(tx_data), 32'(0));
        check_eq("t6_rst_count", 32'(fifo_count), 32'(0));
        check_eq("t6_rst_overrun", 32'(overrun), 32'(0));
        exp_q.delete();
        acc_cnt  = 0;
        rel_cnt  = 0;
        echo_cnt = 0;
        idle(2);
        rst_n = 1'b1;
        s0 = start_cnt;
        idle(30);
        check_eq("t6_no_restart", 32'(start_cnt - s0), 32'(0));
        busy_len = 6;
        send_byte(8'h77, 1'b1, 1'b0);
        drain();
        check_eq("t6_new_launch", 32'(start_cnt - s0), 32'(1));

        // randomized rounds in both modes
        for (int r = 0; r < 24; r++) begin
            mode = 1'($urandom_range(0, 1));
            line_mode = mode;
            busy_len = $urandom_range(1, 20);
            len = mode ? $urandom_range(1, DEPTH - 1) : $urandom_range(1, DEPTH);
            s0 = start_cnt;
            for (int i = 0; i < len; i++) begin
                d = 8'($urandom_range(0, 255));
                if (mode && $urandom_range(0, 7) == 0) d = TERM;
                if (mode && i == len - 1) d = TERM;
                send_byte(d, 1'b1, 1'b0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            drain();
            check_eq("rnd_starts", 32'(start_cnt - s0), 32'(len));
            check_eq("rnd_overrun", 32'(overrun), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
